// File: rtl/defs.sv
// Command opcodes shared between the monitor command master and its slaves.
package tmon_defs;

    typedef enum logic [1:0] {
        NOOP          = 2'd0,
        RESET         = 2'd1,
        SET_FRQ       = 2'd2,
        SET_HIGH_TEMP = 2'd3
    } TMON_OP;

endpackage

// File: rtl/tmon_slave.sv
// tmon_slave: temperature-monitor execution stage.
// Executes op/opnd commands from the monitor master, periodically samples an
// 8-bit sensor over a req/ack handshake and keeps the latest reading plus a
// sticky over-temperature alarm.
//
// Command handshake: a command transfers at a rising edge where valid and
// ready are both high. ready is a registered output that is high only while
// the FSM sits in IDLE; the master must keep op/opnd stable while valid is
// high and ready is low. Each accepted command produces exactly one cmd_done
// pulse one cycle after the accepting edge (unless reset intervenes).
module tmon_slave
    import tmon_defs::*;
#(
    parameter logic [7:0] DEFAULT_FRQ  = 8'd100,
    parameter logic [7:0] DEFAULT_HIGH = 8'd80,
    parameter int         SENS_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  TMON_OP     op,
    input  logic [7:0] opnd,
    input  logic       valid,
    output logic       ready,
    output logic       cmd_done,
    output logic       sens_req,
    input  logic       sens_ack,
    input  logic [7:0] sens_data,
    output logic [7:0] temp,
    output logic       temp_valid,
    output logic       alarm,
    output logic       sens_err,
    output logic       overrun,
    output logic [1:0] o_dbg_state
);

    localparam int         TW      = $clog2(SENS_TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(SENS_TIMEOUT - 1);
    // Down-counter start value; a zero period leaves the counter parked at 0.
    localparam logic [7:0] CNT_RST = (DEFAULT_FRQ == 8'd0) ? 8'd0 : (DEFAULT_FRQ - 8'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_SREQ = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_ready;
    logic          r_cmd_done;
    logic          r_sens_req;
    logic          r_sens_err;
    logic [TW-1:0] r_to_cnt;
    TMON_OP        r_op;
    logic [7:0]    r_opnd;

    logic [7:0]    r_period;
    logic [7:0]    r_high;
    logic [7:0]    r_cnt;
    logic          r_pending;
    logic          r_overrun;

    logic [7:0]    r_temp;
    logic          r_temp_valid;
    logic          r_alarm;

    logic          w_tick;
    logic          w_accept;
    logic          w_start_req;
    logic          w_exec;
    logic          w_ack_done;
    logic          w_timeout;

    // A sample tick fires when an enabled period counter has run down to zero.
    assign w_tick = (r_period != 8'd0) && (r_cnt == 8'd0);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a command beats a pending sample, ack beats timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_start_req = 1'b0;
        w_exec      = 1'b0;
        w_ack_done  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (valid && r_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end else if (r_pending) begin
                    w_start_req = 1'b1;
                    w_state_nxt = ST_SREQ;
                end
            end
            ST_EXEC: begin
                w_exec      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_SREQ: begin
                if (sens_ack) begin
                    w_ack_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs, command latch and sensor-wait timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready    <= 1'b0;
            r_cmd_done <= 1'b0;
            r_sens_req <= 1'b0;
            r_sens_err <= 1'b0;
            r_to_cnt   <= '0;
            r_op       <= NOOP;
            r_opnd     <= 8'd0;
        end else begin
            r_ready    <= (w_state_nxt == ST_IDLE);
            r_cmd_done <= w_exec;
            r_sens_err <= w_timeout;
            if (w_start_req) begin
                r_sens_req <= 1'b1;
            end else if (w_ack_done || w_timeout) begin
                r_sens_req <= 1'b0;
            end
            if (w_start_req) begin
                r_to_cnt <= '0;
            end else if (r_state == ST_SREQ) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end
            if (w_accept) begin
                r_op   <= op;
                r_opnd <= opnd;
            end
        end
    end

    // Period/threshold registers, sample tick counter, pending and overrun flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period  <= DEFAULT_FRQ;
            r_high    <= DEFAULT_HIGH;
            r_cnt     <= CNT_RST;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (r_period != 8'd0) begin
                r_cnt <= w_tick ? (r_period - 8'd1) : (r_cnt - 8'd1);
            end
            if (w_tick) begin
                if (r_pending) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pending <= 1'b1;
                end
            end
            if (w_start_req) begin
                r_pending <= 1'b0;
            end
            // Command effects are applied last so they override the tick.
            if (w_exec) begin
                case (r_op)
                    SET_FRQ: begin
                        r_period <= r_opnd;
                        r_cnt    <= (r_opnd == 8'd0) ? 8'd0 : (r_opnd - 8'd1);
                    end
                    SET_HIGH_TEMP: begin
                        r_high <= r_opnd;
                    end
                    RESET: begin
                        r_period  <= DEFAULT_FRQ;
                        r_high    <= DEFAULT_HIGH;
                        r_cnt     <= CNT_RST;
                        r_pending <= 1'b0;
                        r_overrun <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Sample capture and sticky alarm; only a RESET command clears the alarm.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_temp       <= 8'd0;
            r_temp_valid <= 1'b0;
            r_alarm      <= 1'b0;
        end else begin
            r_temp_valid <= w_ack_done;
            if (w_ack_done) begin
                r_temp <= sens_data;
                if (sens_data > r_high) begin
                    r_alarm <= 1'b1;
                end
            end
            if (w_exec && (r_op == RESET)) begin
                r_alarm <= 1'b0;
            end
        end
    end

    assign ready       = r_ready;
    assign cmd_done    = r_cmd_done;
    assign sens_req    = r_sens_req;
    assign sens_err    = r_sens_err;
    assign temp        = r_temp;
    assign temp_valid  = r_temp_valid;
    assign alarm       = r_alarm;
    assign overrun     = r_overrun;
    assign o_dbg_state = r_state;

endmodule

// File: doc/tmon_slave.md
Name: tmon_slave

Overview:
Temperature-monitor execution stage. It sits directly downstream of the monitor command master and consumes its op/opnd commands over a valid/ready handshake. It holds the sample-period and high-temperature registers, periodically samples an external 8-bit temperature sensor through a req/ack handshake, and reports the latest temperature plus a sticky over-temperature alarm.

Parameters:
DEFAULT_FRQ, 8'd100, sample period in clk cycles loaded at reset and on RESET op (0 = sampling disabled)
DEFAULT_HIGH, 8'd80, high-temperature threshold loaded at reset and on RESET op
SENS_TIMEOUT, 16, max cycles sens_req may wait for sens_ack before abort (>=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
op  in  TMON_OP  command opcode (NOOP, RESET, SET_FRQ, SET_HIGH_TEMP; type from defs.sv)
opnd  in  8  command operand
valid  in  1  command valid from master
ready  out  1  slave can accept a command this cycle
cmd_done  out  1  one-cycle pulse: accepted command has been applied
sens_req  out  1  sample request to sensor, held until ack or timeout
sens_ack  in  1  sensor handshake; qualifies sens_data
sens_data  in  8  unsigned sensor reading
temp  out  8  last successfully sampled temperature
temp_valid  out  1  one-cycle pulse when temp updates
alarm  out  1  sticky: a sample exceeded threshold
sens_err  out  1  one-cycle pulse on sensor timeout
overrun  out  1  sticky: sample tick arrived while one already pending

Behaviour:
- One clock domain; every register updates on posedge clk; reset synchronous, active-high.
- Reset values: ready=0, cmd_done=0, sens_req=0, temp=0, temp_valid=0, alarm=0, sens_err=0, overrun=0; period=DEFAULT_FRQ, high=DEFAULT_HIGH, pending=0, down-counter=DEFAULT_FRQ-1 (0 if disabled); FSM=IDLE. ready rises the first edge after reset deasserts.
- FSM states: IDLE, EXEC, SREQ. ready is registered; it is 1 only while in IDLE.
- IDLE: at an edge with valid&&ready, latch op/opnd, ready<=0, go EXEC (command has priority over a pending sample). Otherwise, if pending=1: pending<=0, sens_req<=1, ready<=0, go SREQ. Otherwise stay.
- EXEC (exactly 1 cycle): apply latched command; cmd_done<=1 and ready<=1 on the exit edge, go IDLE. Accept-to-cmd_done latency is 2 edges; ready is low for exactly 1 cycle.
  NOOP: no state change. SET_FRQ: period<=opnd, counter<=opnd-1 (opnd=0 disables: counter frozen, no new ticks; an existing pending is kept). SET_HIGH_TEMP: high<=opnd; alarm is not re-evaluated until the next sample. RESET: period/high/counter to defaults, alarm<=0, overrun<=0, pending<=0; temp is kept.
- Tick counter: when period!=0, decrements every cycle in all states; on reaching 0 reloads period-1 and sets pending. Tick while pending=1 already sets overrun and is otherwise dropped. period=1 gives a tick every cycle.
- SREQ: sens_req held high. If sens_ack is sampled high: temp<=sens_data, temp_valid<=1, alarm<=alarm|(sens_data>high), where the compare is unsigned and strict. Also sens_req<=0, ready<=1, go IDLE. If SENS_TIMEOUT cycles elapse with no ack: sens_err<=1, temp unchanged, sens_req<=0, ready<=1, go IDLE. Commands are not accepted in SREQ (ready=0).
- If sens_ack arrives on the same edge the timeout expires, the ack wins.
- Pulse outputs (cmd_done, temp_valid, sens_err) last exactly one cycle.
- reset mid-operation (EXEC or SREQ): the latched command is discarded with no cmd_done, sens_req drops on that edge, and all state returns to reset values.

Test Plan:
- Reset then idle, DEFAULT_FRQ=100, sensor acks next cycle with 8'd50: sens_req first rises ~100 cycles after reset; temp=50, temp_valid pulses once, alarm=0.
- SET_FRQ opnd=10 while valid high in IDLE: ready low 1 cycle, cmd_done 2 edges after accept; afterwards sens_req asserts every 10 cycles (+ sample latency).
- SET_HIGH_TEMP opnd=60, then sensor returns 60 -> alarm stays 0; next sample 61 -> alarm=1; a later sample of 20 leaves alarm=1; RESET op -> alarm=0, period back to 100.
- Sensor never acks, SENS_TIMEOUT=16: sens_req high 16 cycles, sens_err pulses once, temp unchanged, ready returns 1.
- SET_FRQ opnd=1 with slow sensor (ack after 5 cycles): overrun=1; RESET op clears it. SET_FRQ opnd=0: no further sens_req.
- Tick and valid on the same IDLE cycle: command accepted first, sample issued right after EXEC; reset asserted during SREQ: sens_req drops next edge, no cmd_done/temp_valid.
